// File: rtl/sysctrl_gen.sv
// sysctrl_gen: core-independent MCU system-control slave.
// Decodes framed command bytes from the MCU link and owns the config
// register file, the latched/maskable interrupt controller, LED and RGB
// registers, button readback and the core-identification reply.
module sysctrl_gen #(
    parameter logic [7:0]             CORE_ID     = 8'h02,
    parameter logic [7:0]             CORE_VER    = 8'h01,
    parameter int                     NUM_LED     = 2,
    parameter int                     NUM_BTN     = 2,
    parameter int                     NUM_INT     = 8,
    parameter int                     CFG_SLOTS   = 16,
    parameter logic [8*CFG_SLOTS-1:0] CFG_DEFAULT = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_in_strobe,
    input  logic                     data_in_start,
    input  logic [7:0]               data_in,
    output logic [7:0]               data_out,
    output logic                     int_out_n,
    input  logic [NUM_INT-1:0]       int_in,
    output logic [NUM_INT-1:0]       int_ack,
    input  logic [NUM_BTN-1:0]       buttons,
    output logic [NUM_LED-1:0]       leds,
    output logic [23:0]              color,
    output logic [8*CFG_SLOTS-1:0]   cfg_out,
    output logic                     cfg_wr,
    output logic [4:0]               cfg_idx
);

    // Colour bytes arrive LSB-first from the MCU side.
    function automatic logic [7:0] rev8(input logic [7:0] b);
        for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
    endfunction

    logic [3:0]             state_q, state_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [7:0]             id_q, id_d;
    logic [7:0]             dout_q, dout_d;
    logic [NUM_LED-1:0]     leds_q, leds_d;
    logic [23:0]            color_q, color_d;
    logic [NUM_INT-1:0]     ack_q, ack_d;
    logic [NUM_INT-1:0]     pend_q, pend_d;
    logic [NUM_INT-1:0]     mask_q, mask_d;
    logic                   int_n_q, int_n_d;
    logic                   wr_q, wr_d;
    logic [4:0]             idx_q, idx_d;
    logic [8*CFG_SLOTS-1:0] cfg_q, cfg_d;
    logic [NUM_BTN-1:0]     btn_s1_q, btn_s2_q;

    logic       proc;
    logic [7:0] slot;
    logic [NUM_INT-1:0] clr;

    // A non-start byte is only acted on inside an open frame.
    assign proc = data_in_strobe && !data_in_start && (state_q != 4'd0);
    assign slot = id_q - 8'h41;

    // Frame byte-position register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= 4'd0;
        else       state_q <= state_d;
    end

    // Start byte opens a frame at position 1; position saturates at 15.
    always_comb begin
        state_d = state_q;
        if (data_in_strobe && data_in_start)  state_d = 4'd1;
        else if (proc && state_q != 4'd15)    state_d = state_q + 4'd1;
    end

    // Per-byte command decode: reply byte and register side effects.
    always_comb begin
        cmd_d   = cmd_q;
        id_d    = id_q;
        dout_d  = dout_q;
        leds_d  = leds_q;
        color_d = color_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        cfg_d   = cfg_q;
        ack_d   = '0;
        wr_d    = 1'b0;
        clr     = '0;
        if (data_in_strobe && data_in_start) cmd_d = data_in;
        if (proc) begin
            dout_d = 8'h00;
            case (cmd_q)
                8'd0: begin
                    case (state_q)
                        4'd1:    dout_d = 8'h5C;
                        4'd2:    dout_d = 8'h42;
                        4'd3:    dout_d = CORE_ID;
                        4'd4:    dout_d = CORE_VER;
                        default: dout_d = 8'h00;
                    endcase
                end
                8'd1: if (state_q == 4'd1) leds_d = data_in[NUM_LED-1:0];
                8'd2: begin
                    case (state_q)
                        4'd1:    color_d[15:8]  = rev8(data_in);
                        4'd2:    color_d[7:0]   = rev8(data_in);
                        4'd3:    color_d[23:16] = rev8(data_in);
                        default: ;
                    endcase
                end
                8'd3: dout_d = 8'(btn_s2_q);
                8'd4: begin
                    if (state_q == 4'd1) id_d = data_in;
                    if (state_q == 4'd2) begin
                        // Out-of-range IDs (including below "A", which wrap) match no slot.
                        for (int n = 0; n < CFG_SLOTS; n++) begin
                            if (slot == 8'(n)) begin
                                cfg_d[8*n +: 8] = data_in;
                                wr_d            = 1'b1;
                                idx_d           = slot[4:0];
                            end
                        end
                    end
                end
                8'd5: begin
                    dout_d = 8'(pend_q);
                    if (state_q == 4'd1) begin
                        ack_d = data_in[NUM_INT-1:0];
                        clr   = data_in[NUM_INT-1:0];
                    end
                end
                8'd6: begin
                    if (state_q == 4'd1) begin
                        dout_d = 8'(mask_q);
                        mask_d = data_in[NUM_INT-1:0];
                    end
                end
                8'd7: begin
                    if (state_q == 4'd1) id_d = data_in;
                    if (state_q == 4'd2) begin
                        for (int n = 0; n < CFG_SLOTS; n++)
                            if (slot == 8'(n)) dout_d = cfg_q[8*n +: 8];
                    end
                end
                default: ;
            endcase
        end
        // New events applied after the ack clear so a coincident event survives.
        pend_d  = (pend_q & ~clr) | int_in;
        int_n_d = ~|(pend_q & mask_q);
    end

    // Datapath registers and the two-flop button synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q    <= 8'h00;
            id_q     <= 8'h00;
            dout_q   <= 8'h00;
            leds_q   <= '0;
            color_q  <= 24'h0;
            ack_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '1;
            int_n_q  <= 1'b1;
            wr_q     <= 1'b0;
            idx_q    <= 5'd0;
            cfg_q    <= CFG_DEFAULT;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            cmd_q    <= cmd_d;
            id_q     <= id_d;
            dout_q   <= dout_d;
            leds_q   <= leds_d;
            color_q  <= color_d;
            ack_q    <= ack_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            int_n_q  <= int_n_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            cfg_q    <= cfg_d;
            btn_s1_q <= buttons;
            btn_s2_q <= btn_s1_q;
        end
    end

    assign data_out  = dout_q;
    assign int_out_n = int_n_q;
    assign int_ack   = ack_q;
    assign leds      = leds_q;
    assign color     = color_q;
    assign cfg_out   = cfg_q;
    assign cfg_wr    = wr_q;
    assign cfg_idx   = idx_q;

endmodule

// File: tb/tb_sysctrl_gen.sv
// Bench for sysctrl_gen: directed test-plan frames followed by random
// framed traffic, every clock compared against a byte-level reference model.
module tb_sysctrl_gen;

    logic         clk = 1'b0;
    logic         reset, data_in_strobe, data_in_start;
    logic [7:0]   data_in, data_out;
    logic         int_out_n;
    logic [7:0]   int_in, int_ack;
    logic [1:0]   buttons, leds;
    logic [23:0]  color;
    logic [127:0] cfg_out;
    logic         cfg_wr;
    logic [4:0]   cfg_idx;

    sysctrl_gen dut (
        .clk(clk), .reset(reset), .data_in_strobe(data_in_strobe),
        .data_in_start(data_in_start), .data_in(data_in), .data_out(data_out),
        .int_out_n(int_out_n), .int_in(int_in), .int_ack(int_ack),
        .buttons(buttons), .leds(leds), .color(color), .cfg_out(cfg_out),
        .cfg_wr(cfg_wr), .cfg_idx(cfg_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference model: frame position, command, and architectural registers.
    int          m_k;
    logic [7:0]  m_cmd, m_id, m_pend, m_mask, m_do, m_ack;
    logic [7:0]  m_cfg [16];
    logic [1:0]  m_leds, m_bh1, m_bh2;
    logic [23:0] m_color;
    logic        m_intn, m_wr;
    logic [4:0]  m_idx;

    function automatic logic [127:0] cfg_flat();
        logic [127:0] v;
        for (int n = 0; n < 16; n++) v[8*n +: 8] = m_cfg[n];
        return v;
    endfunction

    task automatic model(input logic r, input logic s, input logic st,
                         input logic [7:0] d, input logic [7:0] ii);
        logic [7:0] clr;
        logic [1:0] sync_btn;
        int slot;
        m_ack = 8'h00;
        m_wr  = 1'b0;
        if (r) begin
            m_k = 0; m_cmd = 0; m_id = 0; m_pend = 0; m_mask = 8'hFF; m_do = 0;
            m_leds = 0; m_color = 0; m_intn = 1'b1; m_idx = 0;
            m_bh1 = 0; m_bh2 = 0;
            for (int n = 0; n < 16; n++) m_cfg[n] = 8'h00;
            return;
        end
        // Interrupt line reflects the pending/mask state as of the previous clock.
        m_intn = ~|(m_pend & m_mask);
        // Pin value seen by the core two clocks after it was driven.
        sync_btn = m_bh2;
        m_bh2 = m_bh1;
        m_bh1 = buttons;
        clr = 8'h00;
        slot = int'(m_id) - 'h41;
        if (s && st) begin
            m_cmd = d;
            m_k   = 1;
        end else if (s && m_k != 0) begin
            m_do = 8'h00;
            case (m_cmd)
                0: begin
                    if (m_k == 1) m_do = 8'h5C;
                    if (m_k == 2) m_do = 8'h42;
                    if (m_k == 3) m_do = 8'h02;
                    if (m_k == 4) m_do = 8'h01;
                end
                1: if (m_k == 1) m_leds = d[1:0];
                2: begin
                    if (m_k == 1) m_color[15:8]  = {<<{d}};
                    if (m_k == 2) m_color[7:0]   = {<<{d}};
                    if (m_k == 3) m_color[23:16] = {<<{d}};
                end
                3: m_do = {6'b0, sync_btn};
                4: begin
                    if (m_k == 1) m_id = d;
                    if (m_k == 2 && slot >= 0 && slot < 16) begin
                        m_cfg[slot] = d;
                        m_wr  = 1'b1;
                        m_idx = 5'(slot);
                    end
                end
                5: begin
                    m_do = m_pend;
                    if (m_k == 1) begin
                        m_ack = d;
                        clr   = d;
                    end
                end
                6: if (m_k == 1) begin
                    m_do   = m_mask;
                    m_mask = d;
                end
                7: begin
                    if (m_k == 1) m_id = d;
                    if (m_k == 2 && slot >= 0 && slot < 16) m_do = m_cfg[slot];
                end
                default: ;
            endcase
            if (m_k < 15) m_k++;
        end
        m_pend = (m_pend & ~clr) | ii;
    endtask

    task automatic step(input logic s, input logic st, input logic [7:0] d,
                        input logic [7:0] ii, input logic r);
        reset = r; data_in_strobe = s; data_in_start = st; data_in = d; int_in = ii;
        @(posedge clk);
        #1;
        model(r, s, st, d, ii);
        chk("data_out",  data_out,  m_do);
        chk("leds",      leds,      m_leds);
        chk("color",     color,     m_color);
        chk("int_out_n", int_out_n, m_intn);
        chk("int_ack",   int_ack,   m_ack);
        chk("cfg_wr",    cfg_wr,    m_wr);
        chk("cfg_idx",   cfg_idx,   m_idx);
        chk("cfg_out",   cfg_out,   cfg_flat());
        reset = 0; data_in_strobe = 0; data_in_start = 0; int_in = 0;
    endtask

    task automatic cmd(input logic [7:0] c);  step(1, 1, c, 0, 0); endtask
    task automatic byt(input logic [7:0] d);  step(1, 0, d, 0, 0); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
    endtask

    initial begin
        reset = 1; data_in_strobe = 0; data_in_start = 0; data_in = 0;
        int_in = 0; buttons = 0;
        step(0, 0, 0, 0, 1);
        idle(1);

        // 1: identification handshake
        cmd(8'h00); byt(8'h11); byt(8'h22); byt(8'h33); byt(8'h44); idle(1);
        chk("tp1_ver", data_out, 8'h01);

        // 2: config write/read, in and out of range
        cmd(8'h04); byt("C"); byt(8'h03); idle(1);
        chk("tp2_slotC", cfg_out[23:16], 8'h03);
        cmd(8'h07); byt("C"); byt(8'h00); idle(1);
        chk("tp2_rdC", data_out, 8'h03);
        cmd(8'h04); byt("Z"); byt(8'h55); idle(1);
        cmd(8'h07); byt("Z"); byt(8'h00); idle(1);
        chk("tp2_rdZ", data_out, 8'h00);

        // 3: interrupt latch, partial ack, full ack
        step(0, 0, 0, 8'h05, 0); idle(2);
        cmd(8'h05); byt(8'h01); idle(2);
        cmd(8'h05); byt(8'h04); idle(3);

        // 4: coincident set/ack on bit0, then mask off/on
        step(0, 0, 0, 8'h01, 0); idle(1);
        cmd(8'h05); step(1, 0, 8'h01, 8'h01, 0); idle(2);
        cmd(8'h06); byt(8'h00); idle(2);
        chk("tp4_masked", int_out_n, 1'b1);
        cmd(8'h06); byt(8'hFF); idle(2);
        chk("tp4_unmask", int_out_n, 1'b0);

        // 5: colour, LEDs, buttons
        cmd(8'h02); byt(8'h80); byt(8'h01); byt(8'hFF); idle(1);
        chk("tp5_color", color, 24'hFF0180);
        cmd(8'h01); byt(8'h03); idle(1);
        chk("tp5_leds", leds, 2'b11);
        buttons = 2'b10; idle(3);
        cmd(8'h03); byt(8'h00); idle(1);
        chk("tp5_btn", data_out, 8'h02);

        // 6: reset mid-frame abandons it
        cmd(8'h04); byt("A");
        step(0, 0, 0, 0, 1);
        byt(8'h77); idle(1);
        chk("tp6_slotA", cfg_out[7:0], 8'h00);
        cmd(8'h42); byt(8'h00); idle(1);

        // Random framed traffic with background interrupts and button motion
        for (int f = 0; f < 300; f++) begin
            logic [7:0] c;
            int nb;
            if ($urandom_range(0, 49) == 0) step(0, 0, 0, 0, 1);
            c  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            nb = $urandom_range(0, 5);
            cmd(c);
            for (int k = 1; k <= nb; k++) begin
                logic [7:0] d, ii;
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    if ($urandom_range(0, 7) == 0) buttons = 2'($urandom);
                    ii = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                    step(0, 0, 0, ii, 0);
                end
                d = 8'($urandom);
                if ((c == 8'd4 || c == 8'd7) && k == 1 && $urandom_range(0, 4) != 0)
                    d = 8'h41 + 8'($urandom_range(0, 18));
                ii = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                step(1, 0, d, ii, 0);
            end
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
